sync_fifo_status: RTL and testbench

SYNC_FIFO_STATUS -- requirements
Module: sync_fifo_status

---
 rtl/sync_fifo_status.sv | 94 +++++++++
 tb/tb_sync_fifo_status.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_status.sv
// Single-clock FIFO with level, almost-full/almost-empty status, and sticky overflow/underflow flags.
// Supports either a registered read port or a first-word-fall-through read port.
module sync_fifo_status #(
  parameter int DEPTH_WIDTH   = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int AFULL_THRESH  = (1 << ((DEPTH_WIDTH < 1) ? 1 : DEPTH_WIDTH)) - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [((DATA_WIDTH < 1) ? 1 : DATA_WIDTH)-1:0]     wr_data_i,
  input  logic                                               wr_en_i,
  input  logic                                               rd_en_i,
  output logic [((DATA_WIDTH < 1) ? 1 : DATA_WIDTH)-1:0]     rd_data_o,
  output logic                                               full_o,
  output logic                                               empty_o,
  output logic                                               almost_full_o,
  output logic                                               almost_empty_o,
  output logic [((DEPTH_WIDTH < 1) ? 1 : DEPTH_WIDTH):0]     level_o,
  output logic                                               overflow_o,
  output logic                                               underflow_o
);

  localparam int AW    = (DEPTH_WIDTH < 1) ? 1 : DEPTH_WIDTH;
  localparam int DW    = (DATA_WIDTH < 1) ? 1 : DATA_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   level;
  logic          wr_acc;
  logic          rd_acc;
  logic          overflow;
  logic          underflow;

  // A read frees a slot in the same cycle, so a full FIFO may still take a write alongside it.
  always_comb begin
    rd_acc = rd_en_i && (level != '0);
    wr_acc = wr_en_i && ((level != DEPTH_L) || rd_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
      if (wr_en_i && !wr_acc) overflow  <= 1'b1;
      if (rd_en_i && !rd_acc) underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

  always_comb begin
    empty_o        = (level == '0);
    full_o         = (level == DEPTH_L);
    almost_full_o  = (int'(level) >= AFULL_THRESH);
    almost_empty_o = (int'(level) <= AEMPTY_THRESH);
    level_o        = level;
    overflow_o     = overflow;
    underflow_o    = underflow;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data_o = mem[rd_ptr[AW-1:0]];
    end else begin : g_std
      logic [DW-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_q <= '0;
        else if (rd_acc) rd_q <= mem[rd_ptr[AW-1:0]];
      end
      assign rd_data_o = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_status.sv
// Randomized and directed bench for sync_fifo_status, with registered-read and FWFT instances
// checked against a queue-based reference model.
module tb_sync_fifo_status;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;

  logic [7:0] rd_data_s, rd_data_f;
  logic       full_s, empty_s, afull_s, aempty_s, ovf_s, unf_s;
  logic       full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f;
  logic [2:0] level_s, level_f;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [7:0] m_rd = '0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_status #(
    .DEPTH_WIDTH(2), .DATA_WIDTH(8), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)
  ) u_dut (
    .clk(clk), .rst(rst), .wr_data_i(wr_data), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .rd_data_o(rd_data_s), .full_o(full_s), .empty_o(empty_s),
    .almost_full_o(afull_s), .almost_empty_o(aempty_s), .level_o(level_s),
    .overflow_o(ovf_s), .underflow_o(unf_s)
  );

  sync_fifo_status #(
    .DEPTH_WIDTH(2), .DATA_WIDTH(8), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_data_i(wr_data), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .rd_data_o(rd_data_f), .full_o(full_f), .empty_o(empty_f),
    .almost_full_o(afull_f), .almost_empty_o(aempty_f), .level_o(level_f),
    .overflow_o(ovf_f), .underflow_o(unf_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    check("level",      32'(level_s),  32'(sz));
    check("empty",      32'(empty_s),  32'(sz == 0));
    check("full",       32'(full_s),   32'(sz == 4));
    check("afull",      32'(afull_s),  32'(sz >= 3));
    check("aempty",     32'(aempty_s), 32'(sz <= 1));
    check("overflow",   32'(ovf_s),    32'(m_ovf));
    check("underflow",  32'(unf_s),    32'(m_unf));
    check("rd_data",    32'(rd_data_s), 32'(m_rd));
    check("f_level",    32'(level_f),  32'(sz));
    check("f_empty",    32'(empty_f),  32'(sz == 0));
    check("f_full",     32'(full_f),   32'(sz == 4));
    check("f_overflow", 32'(ovf_f),    32'(m_ovf));
    check("f_underflow",32'(unf_f),    32'(m_unf));
    if (sz > 0) check("f_rd_data", 32'(rd_data_f), 32'(q[0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_rd  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Called one time unit after a rising edge; applies one cycle of stimulus.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    int   sz;
    logic racc, wacc;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    sz   = q.size();
    racc = r && (sz > 0);
    wacc = w && ((sz < 4) || racc);
    @(posedge clk);
    if (w && !wacc) m_ovf = 1'b1;
    if (r && !racc) m_unf = 1'b1;
    if (racc) m_rd = q.pop_front();
    if (wacc) q.push_back(d);
    #1;
    check_all();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reset pulse placed strictly between clock edges; outputs must react before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Fill, then drain in order.
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
    repeat (4) step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Write while full is dropped and flagged.
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
    step(1, 0, 8'h55);
    repeat (4) step(0, 1, 8'h00);

    // Read while empty with a concurrent write: no bypass.
    step(1, 1, 8'hAA);
    step(0, 0, 8'h00);

    // Full with concurrent read/write, then wrap the pointers.
    async_reset();
    step(1, 0, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03); step(1, 0, 8'h04);
    step(1, 1, 8'h66);
    for (int i = 0; i < 12; i++) step(1, 1, 8'($urandom));
    repeat (4) step(0, 1, 8'h00);

    // Mid-operation reset discards contents.
    step(1, 0, 8'hC1); step(1, 0, 8'hC2); step(1, 0, 8'hC3);
    async_reset();
    step(1, 0, 8'h77);
    step(0, 1, 8'h00);

    // Randomized traffic in phases of varying write/read bias.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = 20 + int'($urandom_range(0, 60));
      rp = 20 + int'($urandom_range(0, 60));
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 99) < 2) async_reset();
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
